// File: rtl/pwl_coef_selector.sv
// pwl_coef_selector: two-stage pipelined piecewise-linear coefficient selector.
// Finds the segment of signed operand x against a per-mode breakpoint table.
// Emits that segment's slope k and intercept b, aligned with x.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cfg_we/mode/seg/sel/data runtime table write (sel: 0 bp, 1 k, 2 b, 3 ignored)
//   in_valid/in_ready        input handshake; in_mode, in_x operand payload
//   out_valid/out_ready      output handshake
//   out_x/k/b/seg/mode/err   aligned operand, coefficients, segment, mode, bad-mode flag
module pwl_coef_selector #(
   parameter int unsigned FIX_POINT_WIDTH = 16,
   parameter int unsigned SEG_NUM         = 8,
   parameter int unsigned MODE_NUM        = 4,
   parameter int unsigned MODE_W          = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cfg_we,
   input  logic [MODE_W-1:0]            cfg_mode,
   input  logic [$clog2(SEG_NUM)-1:0]   cfg_seg,
   input  logic [1:0]                   cfg_sel,
   input  logic [FIX_POINT_WIDTH-1:0]   cfg_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [MODE_W-1:0]            in_mode,
   input  logic [FIX_POINT_WIDTH-1:0]   in_x,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [FIX_POINT_WIDTH-1:0]   out_x,
   output logic [FIX_POINT_WIDTH-1:0]   out_k,
   output logic [FIX_POINT_WIDTH-1:0]   out_b,
   output logic [$clog2(SEG_NUM)-1:0]   out_seg,
   output logic [MODE_W-1:0]            out_mode,
   output logic                         out_err
);

   localparam int unsigned W     = FIX_POINT_WIDTH;
   localparam int unsigned SEG_W = $clog2(SEG_NUM);

   logic signed [W-1:0] bp_q [MODE_NUM][SEG_NUM];
   logic signed [W-1:0] k_q  [MODE_NUM][SEG_NUM];
   logic signed [W-1:0] b_q  [MODE_NUM][SEG_NUM];

   logic                 s1_valid;
   logic [W-1:0]         s1_x;
   logic [MODE_W-1:0]    s1_mode;
   logic                 s1_err;
   logic [SEG_NUM-1:1]   s1_ge;

   logic                 en_c;
   logic                 cfg_ok_c;
   logic                 in_err_c;
   logic [MODE_W-1:0]    in_rd_mode_c;
   logic [SEG_NUM-1:1]   ge_c;
   logic [SEG_W-1:0]     seg_c;
   logic [MODE_W-1:0]    s1_rd_mode_c;
   logic signed [W-1:0]  k_rd_c;
   logic signed [W-1:0]  b_rd_c;

   // Pipeline advances whenever the output register is empty or being drained
   assign en_c     = out_ready | ~out_valid;
   assign in_ready = en_c;

   // Input-side decode and breakpoint comparisons; bad modes read mode 0 safely
   always_comb begin
      in_err_c     = (32'(in_mode) >= MODE_NUM);
      in_rd_mode_c = in_err_c ? '0 : in_mode;
      ge_c         = '0;
      for (int unsigned j = 1; j < SEG_NUM; j++) begin
         ge_c[SEG_W'(j)] = ($signed(in_x) >= bp_q[in_rd_mode_c][SEG_W'(j)]);
      end
   end

   // Segment is the number of breakpoints at or below x, then coefficient lookup
   always_comb begin
      seg_c = '0;
      for (int unsigned j = 1; j < SEG_NUM; j++) begin
         seg_c = seg_c + SEG_W'(s1_ge[SEG_W'(j)]);
      end
      s1_rd_mode_c = s1_err ? '0 : s1_mode;
      k_rd_c       = k_q[s1_rd_mode_c][seg_c];
      b_rd_c       = b_q[s1_rd_mode_c][seg_c];
   end

   assign cfg_ok_c = cfg_we && (32'(cfg_mode) < MODE_NUM) && (cfg_sel != 2'd3);

   // Coefficient tables, writable at runtime
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int m = 0; m < int'(MODE_NUM); m++) begin
            for (int j = 0; j < int'(SEG_NUM); j++) begin
               bp_q[m][j] <= '0;
               k_q[m][j]  <= '0;
               b_q[m][j]  <= '0;
            end
         end
      end else if (cfg_ok_c) begin
         case (cfg_sel)
            2'd0:    bp_q[cfg_mode][cfg_seg] <= cfg_data;
            2'd1:    k_q[cfg_mode][cfg_seg]  <= cfg_data;
            2'd2:    b_q[cfg_mode][cfg_seg]  <= cfg_data;
            default: ;
         endcase
      end
   end

   // Stage 1: accept operand and latch comparison results
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_mode  <= '0;
         s1_err   <= 1'b0;
         s1_ge    <= '0;
      end else if (en_c) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_x    <= in_x;
            s1_mode <= in_mode;
            s1_err  <= in_err_c;
            s1_ge   <= ge_c;
         end
      end
   end

   // Stage 2: register segment, coefficients and aligned operand
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_x     <= '0;
         out_k     <= '0;
         out_b     <= '0;
         out_seg   <= '0;
         out_mode  <= '0;
         out_err   <= 1'b0;
      end else if (en_c) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_x    <= s1_x;
            out_mode <= s1_mode;
            out_err  <= s1_err;
            out_seg  <= s1_err ? '0 : seg_c;
            out_k    <= s1_err ? '0 : k_rd_c;
            out_b    <= s1_err ? '0 : b_rd_c;
         end
      end
   end

endmodule
